conv2d_mc: RTL and testbench

//  Multi-channel, multi-filter 2D convolution engine. Second-generation conv stage of the CNN datapath.

---
 rtl/conv2d_mc_pkg.sv | 31 +++
 rtl/conv2d_mc_mac_sat.sv | 52 +++++
 rtl/conv2d_mc.sv | 183 ++++++++++++++++++
 tb/tb_conv2d_mc.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_mc_pkg.sv
// Shared Q-format defaults, FSM state encoding and the saturation helper for the conv engine.
package conv2d_mc_pkg;

  localparam int unsigned Q_DATA_W = 16;
  localparam int unsigned Q_FRAC   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StDrain,
    StStore,
    StDone
  } state_e;

  // Clamp v into the signed w-bit range; optionally force negatives to zero.
  function automatic logic signed [63:0] sat_q(input logic signed [63:0] v,
                                               input int unsigned w,
                                               input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    else r = v;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/conv2d_mc_mac_sat.sv
// Accumulator for one output: load bias, accumulate products, then shift/saturate/ReLU.
module conv2d_mc_mac_sat
  import conv2d_mc_pkg::*;
#(
  parameter int unsigned DATA_W  = Q_DATA_W,
  parameter int unsigned FRAC    = Q_FRAC,
  parameter int unsigned ACC_W   = 2 * Q_DATA_W + 5,
  parameter int unsigned RELU_EN = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  output logic signed [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_sh;
  logic signed [63:0]         acc_wide;

  assign prod     = pixel * weight;
  assign prod_ext = ACC_W'(prod);

  always_comb begin
    bias_ext = ACC_W'(bias);
    bias_ext = bias_ext <<< FRAC;
  end

  always_comb begin
    acc_d = acc_q;
    if (load) acc_d = bias_ext;
    else if (acc_en) acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else acc_q <= acc_d;
  end

  // Result reflects the next accumulator value so the final tap is included when it is captured.
  assign acc_sh   = acc_d >>> FRAC;
  assign acc_wide = 64'(acc_sh);
  assign result   = DATA_W'(sat_q(acc_wide, DATA_W, RELU_EN != 0));

endmodule

// File: rtl/conv2d_mc.sv
// Multi-channel multi-filter 2D convolution: sequences taps over external RAM, one MAC per cycle.
module conv2d_mc
  import conv2d_mc_pkg::*;
#(
  parameter int unsigned IN_W    = 64,
  parameter int unsigned IN_H    = 64,
  parameter int unsigned IN_C    = 1,
  parameter int unsigned K       = 3,
  parameter int unsigned NUM_F   = 8,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned DATA_W  = Q_DATA_W,
  parameter int unsigned FRAC    = Q_FRAC,
  parameter int unsigned RELU_EN = 0,
  localparam int unsigned OW     = (IN_W - K) / STRIDE + 1,
  localparam int unsigned OH     = (IN_H - K) / STRIDE + 1,
  localparam int unsigned TAPS   = IN_C * K * K,
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(TAPS) + 1,
  localparam int unsigned WA_W   = (NUM_F * TAPS > 1) ? $clog2(NUM_F * TAPS) : 1,
  localparam int unsigned BA_W   = (NUM_F > 1) ? $clog2(NUM_F) : 1,
  localparam int unsigned IA_W   = (IN_C * IN_H * IN_W > 1) ? $clog2(IN_C * IN_H * IN_W) : 1,
  localparam int unsigned OA_W   = (NUM_F * OH * OW > 1) ? $clog2(NUM_F * OH * OW) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     w_we,
  input  logic [WA_W-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic                     b_we,
  input  logic [BA_W-1:0]          b_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     in_rd_en,
  output logic [IA_W-1:0]          in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [OA_W-1:0]          out_addr
);

  logic signed [DATA_W-1:0] weights [NUM_F*TAPS];
  logic signed [DATA_W-1:0] biases  [NUM_F];
  logic signed [DATA_W-1:0] w_pipe_q;
  logic signed [DATA_W-1:0] result;

  state_e      state_q;
  int unsigned tap_q, c_q, ky_q, kx_q;
  int unsigned ox_q, oy_q, f_q;

  logic [WA_W-1:0] w_idx;
  logic [BA_W-1:0] b_idx;
  logic            last_pos;
  logic            mac_load;
  logic            mac_acc;

  assign w_idx    = WA_W'(f_q * TAPS + tap_q);
  assign b_idx    = BA_W'(f_q);
  assign last_pos = (f_q == NUM_F - 1) && (oy_q == OH - 1) && (ox_q == OW - 1);
  assign in_addr  = IA_W'(c_q * IN_H * IN_W + (oy_q * STRIDE + ky_q) * IN_W
                          + ox_q * STRIDE + kx_q);

  // Storage is deliberately not reset; writes are locked out during a pass.
  always_ff @(posedge clk) begin
    if (w_we && !busy && (32'(w_addr) < NUM_F * TAPS)) weights[w_addr] <= w_data;
    if (b_we && !busy && (32'(b_addr) < NUM_F)) biases[b_addr] <= b_data;
  end

  // Weight delayed one cycle to line up with the registered RAM read data.
  always_ff @(posedge clk) begin
    w_pipe_q <= weights[w_idx];
  end

  // Bias is loaded on the first tap cycle, so a write coinciding with start is already visible.
  assign mac_load = (state_q == StMac) && (tap_q == 0);
  assign mac_acc  = ((state_q == StMac) && (tap_q != 0)) || (state_q == StDrain);

  conv2d_mc_mac_sat #(
    .DATA_W  (DATA_W),
    .FRAC    (FRAC),
    .ACC_W   (ACC_W),
    .RELU_EN (RELU_EN)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .load   (mac_load),
    .acc_en (mac_acc),
    .bias   (biases[b_idx]),
    .pixel  (in_data),
    .weight (w_pipe_q),
    .result (result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_rd_en  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      tap_q     <= 0;
      c_q       <= 0;
      ky_q      <= 0;
      kx_q      <= 0;
      ox_q      <= 0;
      oy_q      <= 0;
      f_q       <= 0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StMac;
            busy     <= 1'b1;
            in_rd_en <= 1'b1;
          end
        end
        StMac: begin
          if (tap_q == TAPS - 1) begin
            state_q  <= StDrain;
            in_rd_en <= 1'b0;
            tap_q    <= 0;
            c_q      <= 0;
            ky_q     <= 0;
            kx_q     <= 0;
          end else begin
            tap_q <= tap_q + 1;
            if (kx_q == K - 1) begin
              kx_q <= 0;
              if (ky_q == K - 1) begin
                ky_q <= 0;
                c_q  <= c_q + 1;
              end else begin
                ky_q <= ky_q + 1;
              end
            end else begin
              kx_q <= kx_q + 1;
            end
          end
        end
        StDrain: begin
          state_q   <= StStore;
          out_valid <= 1'b1;
          out_data  <= result;
          out_addr  <= OA_W'(f_q * OH * OW + oy_q * OW + ox_q);
        end
        StStore: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_pos) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              ox_q    <= 0;
              oy_q    <= 0;
              f_q     <= 0;
            end else begin
              state_q  <= StMac;
              in_rd_en <= 1'b1;
              if (ox_q == OW - 1) begin
                ox_q <= 0;
                if (oy_q == OH - 1) begin
                  oy_q <= 0;
                  f_q  <= f_q + 1;
                end else begin
                  oy_q <= oy_q + 1;
                end
              end else begin
                ox_q <= ox_q + 1;
              end
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_mc.sv
// Directed bench for conv2d_mc: three small instances (single-channel, strided multi-channel, ReLU).
module tb_conv2d_mc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic out_ready = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  // Instance A (4x4, 1 channel, 1 filter) and C (same, ReLU) share the weight bus and input map.
  logic        a_start = 1'b0, a_busy, a_done;
  logic        a_w_we = 1'b0;
  logic [3:0]  a_w_addr = '0;
  logic [15:0] a_w_data = '0;
  logic        a_b_we = 1'b0;
  logic [0:0]  a_b_addr = '0;
  logic [15:0] a_b_data = '0;
  logic        a_rd, a_ov;
  logic [3:0]  a_in_addr;
  logic [15:0] a_in_data, a_od;
  logic [1:0]  a_oa;
  logic [15:0] a_mem [16];

  logic        c_start = 1'b0, c_busy, c_done, c_rd, c_ov;
  logic [3:0]  c_in_addr;
  logic [15:0] c_in_data, c_od;
  logic [1:0]  c_oa;

  // Instance B (5x5, 2 channels, 2 filters, stride 2).
  logic        b_start = 1'b0, b_busy, b_done;
  logic        b_w_we = 1'b0;
  logic [5:0]  b_w_addr = '0;
  logic [15:0] b_w_data = '0;
  logic        b_b_we = 1'b0;
  logic [0:0]  b_b_addr = '0;
  logic [15:0] b_b_data = '0;
  logic        b_rd, b_ov;
  logic [5:0]  b_in_addr;
  logic [15:0] b_in_data, b_od;
  logic [2:0]  b_oa;
  logic [15:0] b_mem [50];

  logic [15:0] a_qd[$], b_qd[$], c_qd[$];
  logic [1:0]  a_qa[$], c_qa[$];
  logic [2:0]  b_qa[$];
  int          a_dc = 0, b_dc = 0, c_dc = 0;

  localparam logic [15:0] ExpRamp [4] = '{16'h2D00, 16'h3600, 16'h5100, 16'h5A00};

  conv2d_mc #(.IN_W(4), .IN_H(4), .IN_C(1), .K(3), .NUM_F(1), .STRIDE(1), .RELU_EN(0)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
    .w_we(a_w_we), .w_addr(a_w_addr), .w_data(a_w_data),
    .b_we(a_b_we), .b_addr(a_b_addr), .b_data(a_b_data),
    .in_rd_en(a_rd), .in_addr(a_in_addr), .in_data(a_in_data),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_addr(a_oa)
  );

  conv2d_mc #(.IN_W(4), .IN_H(4), .IN_C(1), .K(3), .NUM_F(1), .STRIDE(1), .RELU_EN(1)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .busy(c_busy), .done(c_done),
    .w_we(a_w_we), .w_addr(a_w_addr), .w_data(a_w_data),
    .b_we(a_b_we), .b_addr(a_b_addr), .b_data(a_b_data),
    .in_rd_en(c_rd), .in_addr(c_in_addr), .in_data(c_in_data),
    .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .out_addr(c_oa)
  );

  conv2d_mc #(.IN_W(5), .IN_H(5), .IN_C(2), .K(3), .NUM_F(2), .STRIDE(2), .RELU_EN(0)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
    .w_we(b_w_we), .w_addr(b_w_addr), .w_data(b_w_data),
    .b_we(b_b_we), .b_addr(b_b_addr), .b_data(b_b_data),
    .in_rd_en(b_rd), .in_addr(b_in_addr), .in_data(b_in_data),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .out_addr(b_oa)
  );

  always @(posedge clk) begin
    if (a_rd) a_in_data <= a_mem[a_in_addr];
    if (c_rd) c_in_data <= a_mem[c_in_addr];
    if (b_rd) b_in_data <= b_mem[b_in_addr];
  end

  always @(negedge clk) begin
    if (a_ov && out_ready) begin a_qd.push_back(a_od); a_qa.push_back(a_oa); end
    if (c_ov && out_ready) begin c_qd.push_back(c_od); c_qa.push_back(c_oa); end
    if (b_ov && out_ready) begin b_qd.push_back(b_od); b_qa.push_back(b_oa); end
    if (a_done) a_dc++;
    if (b_done) b_dc++;
    if (c_done) c_dc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(input logic [15:0] val, input bit ramp);
    for (int i = 0; i < 16; i++) a_mem[i] = ramp ? 16'(i * 256) : val;
  endtask

  task automatic load_ac(input logic [15:0] w, input logic [15:0] bv);
    for (int i = 0; i < 9; i++) begin
      a_w_we = 1'b1; a_w_addr = 4'(i); a_w_data = w;
      step();
    end
    a_w_we = 1'b0;
    a_b_we = 1'b1; a_b_addr = 1'b0; a_b_data = bv;
    step();
    a_b_we = 1'b0;
  endtask

  // sel: 0=A, 1=B, 2=C. poke drives start on A during its done cycle.
  task automatic wait_done(input int sel, input int budget, input bit poke, input string name);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = (sel == 0) ? a_done : (sel == 1) ? b_done : c_done;
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("FAIL %s_done_timeout: got no done, want done within %0d cycles", name, budget);
    end
    if (seen && poke) begin
      a_start = 1'b1;
      step();
      a_start = 1'b0;
    end
  endtask

  task automatic run_a(input string name);
    a_qd.delete(); a_qa.delete();
    a_start = 1'b1; step(); a_start = 1'b0;
    wait_done(0, 200, 1'b0, name);
    repeat (3) step();
  endtask

  task automatic run_c(input string name);
    c_qd.delete(); c_qa.delete();
    c_start = 1'b1; step(); c_start = 1'b0;
    wait_done(2, 200, 1'b0, name);
    repeat (3) step();
  endtask

  task automatic check_reset_values(input string name);
    tests++; if (a_busy !== 1'b0) begin failed++; $display("FAIL %s_busy: got %b want 0", name, a_busy); end
    tests++; if (a_done !== 1'b0) begin failed++; $display("FAIL %s_done: got %b want 0", name, a_done); end
    tests++; if (a_rd !== 1'b0) begin failed++; $display("FAIL %s_rd_en: got %b want 0", name, a_rd); end
    tests++; if (a_in_addr !== 4'd0) begin failed++; $display("FAIL %s_in_addr: got %h want 0", name, a_in_addr); end
    tests++; if (a_ov !== 1'b0) begin failed++; $display("FAIL %s_out_valid: got %b want 0", name, a_ov); end
    tests++; if (a_od !== 16'h0) begin failed++; $display("FAIL %s_out_data: got %h want 0000", name, a_od); end
    tests++; if (a_oa !== 2'd0) begin failed++; $display("FAIL %s_out_addr: got %h want 0", name, a_oa); end
  endtask

  task automatic check_a_outputs(input string name, input logic [15:0] expv, input bit ramp);
    logic [15:0] d, w;
    logic [1:0]  ad;
    tests++;
    if (a_qd.size() != 4) begin
      failed++; $display("FAIL %s_count: got %0d want 4", name, a_qd.size());
    end
    for (int i = 0; i < 4; i++) begin
      d  = (i < a_qd.size()) ? a_qd[i] : 16'hxxxx;
      ad = (i < a_qa.size()) ? a_qa[i] : 2'bxx;
      w  = ramp ? ExpRamp[i] : expv;
      tests++; if (d !== w) begin failed++; $display("FAIL %s_data%0d: got %h want %h", name, i, d, w); end
      tests++; if (ad !== 2'(i)) begin failed++; $display("FAIL %s_addr%0d: got %0d want %0d", name, i, ad, i); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();
    check_reset_values("reset");
    tests++; if (b_busy !== 1'b0 || b_ov !== 1'b0) begin
      failed++; $display("FAIL reset_b: got busy=%b valid=%b want 0 0", b_busy, b_ov);
    end
    tests++; if (c_busy !== 1'b0) begin failed++; $display("FAIL reset_c_busy: got %b want 0", c_busy); end
  endtask

  task automatic test_basic();
    int dc0;
    fill_a(16'h0100, 1'b0);
    load_ac(16'h0100, 16'h0000);
    a_qd.delete(); a_qa.delete();
    dc0 = a_dc;
    a_start = 1'b1; step(); a_start = 1'b0;
    repeat (15) step();
    // Mid-pass start and weight write must both be ignored.
    a_start = 1'b1; a_w_we = 1'b1; a_w_addr = '0; a_w_data = '0;
    step();
    a_start = 1'b0; a_w_we = 1'b0;
    wait_done(0, 200, 1'b0, "basic");
    repeat (5) step();
    check_a_outputs("basic", 16'h0900, 1'b0);
    tests++; if (a_dc - dc0 != 1) begin failed++; $display("FAIL basic_done_count: got %0d want 1", a_dc - dc0); end
    tests++; if (a_busy !== 1'b0) begin failed++; $display("FAIL basic_busy_after: got %b want 0", a_busy); end
  endtask

  task automatic test_bias_latency();
    int n = 0;
    int lat = 0;
    bit busy_seen = 1'b0;
    int dc0;
    load_ac(16'h0100, 16'h0080);
    a_qd.delete(); a_qa.delete();
    dc0 = a_dc;
    a_start = 1'b1; step(); a_start = 1'b0;
    while (!a_rd && n < 20) begin step(); n++; end
    while (!a_ov && lat < 30) begin step(); lat++; end
    tests++; if (lat != 10) begin failed++; $display("FAIL bias_latency: got %0d want 10", lat); end
    wait_done(0, 200, 1'b1, "bias");
    repeat (5) begin step(); if (a_busy) busy_seen = 1'b1; end
    tests++; if (busy_seen) begin failed++; $display("FAIL bias_start_in_done: got busy=1 want 0"); end
    check_a_outputs("bias", 16'h0980, 1'b0);
    tests++; if (a_dc - dc0 != 1) begin failed++; $display("FAIL bias_done_count: got %0d want 1", a_dc - dc0); end
  endtask

  task automatic test_multichannel();
    logic [15:0] d, w;
    logic [2:0]  ad;
    for (int i = 0; i < 50; i++) b_mem[i] = (i < 25) ? 16'h0100 : 16'h0200;
    for (int i = 0; i < 35; i++) begin
      b_w_we = 1'b1; b_w_addr = 6'(i); b_w_data = (i < 18) ? 16'h0100 : 16'hFF00;
      step();
    end
    b_w_we = 1'b0;
    for (int f = 0; f < 2; f++) begin
      b_b_we = 1'b1; b_b_addr = 1'(f); b_b_data = 16'h0000;
      step();
    end
    b_b_we = 1'b0;
    b_qd.delete(); b_qa.delete();
    // Last weight lands in the same cycle as start.
    b_w_we = 1'b1; b_w_addr = 6'd35; b_w_data = 16'hFF00; b_start = 1'b1;
    step();
    b_w_we = 1'b0; b_start = 1'b0;
    wait_done(1, 600, 1'b0, "multi");
    repeat (3) step();
    tests++; if (b_qd.size() != 8) begin failed++; $display("FAIL multi_count: got %0d want 8", b_qd.size()); end
    for (int i = 0; i < 8; i++) begin
      d  = (i < b_qd.size()) ? b_qd[i] : 16'hxxxx;
      ad = (i < b_qa.size()) ? b_qa[i] : 3'bxxx;
      w  = (i < 4) ? 16'h1B00 : 16'hE500;
      tests++; if (d !== w) begin failed++; $display("FAIL multi_data%0d: got %h want %h", i, d, w); end
      tests++; if (ad !== 3'(i)) begin failed++; $display("FAIL multi_addr%0d: got %0d want %0d", i, ad, i); end
    end
  endtask

  task automatic test_saturation();
    fill_a(16'h7FFF, 1'b0);
    load_ac(16'h7FFF, 16'h0000);
    run_a("sat_pos");
    check_a_outputs("sat_pos", 16'h7FFF, 1'b0);
    load_ac(16'h8000, 16'h0000);
    run_a("sat_neg");
    check_a_outputs("sat_neg", 16'h8000, 1'b0);
    run_c("relu");
    tests++; if (c_qd.size() != 4) begin failed++; $display("FAIL relu_count: got %0d want 4", c_qd.size()); end
    for (int i = 0; i < c_qd.size(); i++) begin
      tests++; if (c_qd[i] !== 16'h0000) begin
        failed++; $display("FAIL relu_data%0d: got %h want 0000", i, c_qd[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int  n = 0;
    bit  found = 1'b0;
    bit  stable_ok = 1'b1;
    bit  rd_quiet = 1'b1;
    fill_a(16'h0000, 1'b1);
    load_ac(16'h0100, 16'h0000);
    a_qd.delete(); a_qa.delete();
    a_start = 1'b1; step(); a_start = 1'b0;
    while (!found && n < 100) begin
      step(); n++;
      found = a_ov && (a_oa == 2'd1);
    end
    tests++; if (!found) begin failed++; $display("FAIL bp_second_output: got none want valid at addr 1"); end
    out_ready = 1'b0;
    repeat (5) begin
      step();
      if (a_ov !== 1'b1 || a_oa !== 2'd1 || a_od !== 16'h3600) stable_ok = 1'b0;
      if (a_rd !== 1'b0) rd_quiet = 1'b0;
    end
    out_ready = 1'b1;
    tests++; if (!stable_ok) begin failed++; $display("FAIL bp_stable: got changed outputs want held 3600@1"); end
    tests++; if (!rd_quiet) begin failed++; $display("FAIL bp_rd_en: got read during stall want none"); end
    wait_done(0, 200, 1'b0, "bp");
    repeat (3) step();
    check_a_outputs("bp", 16'h0000, 1'b1);
  endtask

  task automatic test_reset_midpass();
    int n = 0;
    fill_a(16'h0100, 1'b0);
    load_ac(16'h0100, 16'h0000);
    a_qd.delete(); a_qa.delete();
    a_start = 1'b1; step(); a_start = 1'b0;
    while (a_qd.size() < 1 && n < 100) begin step(); n++; end
    repeat (4) step();
    tests++; if (a_rd !== 1'b1) begin failed++; $display("FAIL midreset_precond: got rd_en=%b want 1", a_rd); end
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    run_a("restart");
    check_a_outputs("restart", 16'h0900, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish before 300us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_bias_latency();
    test_multichannel();
    test_saturation();
    test_backpressure();
    test_reset_midpass();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
